// File: rtl/mac_loop_ctrl_pkg.sv
// Shared definitions for the mac_loop_ctrl dot-product sequencer.
//   - MAC_* opcodes driven onto c_macop_o. The values must match the
//     opcode decode inside mac_dp.
//   - macctrl_state_e: sequencer state encoding.
//   - elem_macop(): opcode for one loop element.
// Optional feature macro used by the RTL files: MACCTRL_CIRC_A_EN.
package mac_loop_ctrl_pkg;

   localparam logic [3:0] MAC_NOP        = 4'h0;
   localparam logic [3:0] MAC_MUL        = 4'h1;
   localparam logic [3:0] MAC_MAC        = 4'h2;
   localparam logic [3:0] MAC_MDM        = 4'h3;
   localparam logic [3:0] MAC_CLR        = 4'h4;
   localparam logic [3:0] MAC_MOVE_ROUND = 4'h5;

   // Cycles between the last issue and that element's accumulate write.
   localparam int unsigned DRAIN_CYCLES = 3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_DRAIN = 3'd2,
      ST_CLR   = 3'd3,
      ST_ROUND = 3'd4,
      ST_DONE  = 3'd5
   } macctrl_state_e;

   // The first element overwrites the ACR with a plain multiply unless the
   // loop continues an existing accumulation.
   function automatic logic [3:0] elem_macop(input logic first,
                                             input logic keep_acc,
                                             input logic sub);
      if (first && !keep_acc) return MAC_MUL;
      return sub ? MAC_MDM : MAC_MAC;
   endfunction

endpackage

// File: rtl/mac_loop_agu.sv
// Operand address generator for mac_loop_ctrl.
// Two address counters (memory A and memory B). load_i copies the base
// addresses; inc_i advances both by one, modulo 2**AW.
// With MACCTRL_CIRC_A_EN defined, the A counter wraps back to its base after
// circ_len_i elements (circ_len_i latched on load; 0 disables the wrap).
// Ports:
//   clk_i, reset_i      clock, asynchronous active-low reset
//   load_i, inc_i       base load / advance (never both in one cycle)
//   base_a_i, base_b_i  start addresses
//   circ_len_i          A wrap length (only with MACCTRL_CIRC_A_EN)
//   addr_a_o, addr_b_o  current addresses
module mac_loop_agu #(
   parameter int AW = 8
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          load_i,
   input  logic          inc_i,
   input  logic [AW-1:0] base_a_i,
   input  logic [AW-1:0] base_b_i,
`ifdef MACCTRL_CIRC_A_EN
   input  logic [AW-1:0] circ_len_i,
`endif
   output logic [AW-1:0] addr_a_o,
   output logic [AW-1:0] addr_b_o
);

   logic [AW-1:0] addr_a_q, addr_a_d;
   logic [AW-1:0] addr_b_q, addr_b_d;
`ifdef MACCTRL_CIRC_A_EN
   logic [AW-1:0] base_a_q, base_a_d;
   logic [AW-1:0] circ_q, circ_d;
   logic [AW-1:0] off_q, off_d;
`endif

   always_comb begin
      addr_a_d = addr_a_q;
      addr_b_d = addr_b_q;
`ifdef MACCTRL_CIRC_A_EN
      base_a_d = base_a_q;
      circ_d   = circ_q;
      off_d    = off_q;
`endif
      if (load_i) begin
         addr_a_d = base_a_i;
         addr_b_d = base_b_i;
`ifdef MACCTRL_CIRC_A_EN
         base_a_d = base_a_i;
         circ_d   = circ_len_i;
         off_d    = '0;
`endif
      end else if (inc_i) begin
         addr_b_d = addr_b_q + AW'(1);
`ifdef MACCTRL_CIRC_A_EN
         // off_q tracks the position inside the circular window.
         if ((circ_q != '0) && (off_q == circ_q - AW'(1))) begin
            addr_a_d = base_a_q;
            off_d    = '0;
         end else begin
            addr_a_d = addr_a_q + AW'(1);
            off_d    = off_q + AW'(1);
         end
`else
         addr_a_d = addr_a_q + AW'(1);
`endif
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         addr_a_q <= '0;
         addr_b_q <= '0;
`ifdef MACCTRL_CIRC_A_EN
         base_a_q <= '0;
         circ_q   <= '0;
         off_q    <= '0;
`endif
      end else begin
         addr_a_q <= addr_a_d;
         addr_b_q <= addr_b_d;
`ifdef MACCTRL_CIRC_A_EN
         base_a_q <= base_a_d;
         circ_q   <= circ_d;
         off_q    <= off_d;
`endif
      end
   end

   assign addr_a_o = addr_a_q;
   assign addr_b_o = addr_b_q;

endmodule

// File: rtl/mac_loop_ctrl.sv
// Dot-product loop sequencer for mac_dp: sum(A[i]*B[i]), i = 0..len-1.
// Flow: IDLE -> ISSUE (len cycles) -> DRAIN (3) -> [ROUND] -> DONE -> IDLE.
// len = 0 goes through a single CLR write (or nothing when keep_acc) instead.
// An element issued in cycle t gets its operand load at t+1 and its
// accumulate opcode plus ACR write at t+3. A 3-deep (valid, first) tag pipe
// tracks this timing.
// Optional macro MACCTRL_CIRC_A_EN adds circ_len_i for circular A addressing.
// Ports:
//   clk_i, reset_i                  clock, asynchronous active-low reset
//   start_i, abort_i                loop start (IDLE only) / abandon loop
//   len_i, base_a_i, base_b_i       loop count and operand base addresses
//   sub_i, keep_acc_i, rnd_i        MDM vs MAC, continue ACR, append round
//   sat_i, scale_i, acr_i           c_dosat / c_scalefactor / ACR index
//   ovf_flags_i                     overflow/saturation flags from mac_dp
//   addr_a_o, addr_b_o, mem_re_o    operand memory read port
//   op_ld_o                         operand register load strobe
//   c_macop_o, c_dosat_o,
//   c_scalefactor_o                 mac_dp controls
//   acr_sel_o, acr_we_o             ACR index / write enable
//   busy_o, done_o, ovf_o           status
module mac_loop_ctrl
   import mac_loop_ctrl_pkg::*;
#(
   parameter int AW    = 8,
   parameter int LEN_W = 8
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic [AW-1:0]    base_a_i,
   input  logic [AW-1:0]    base_b_i,
   input  logic             sub_i,
   input  logic             keep_acc_i,
   input  logic             rnd_i,
   input  logic             sat_i,
   input  logic [2:0]       scale_i,
   input  logic [1:0]       acr_i,
`ifdef MACCTRL_CIRC_A_EN
   input  logic [AW-1:0]    circ_len_i,
`endif
   input  logic [2:0]       ovf_flags_i,
   output logic [AW-1:0]    addr_a_o,
   output logic [AW-1:0]    addr_b_o,
   output logic             mem_re_o,
   output logic             op_ld_o,
   output logic [3:0]       c_macop_o,
   output logic             c_dosat_o,
   output logic [2:0]       c_scalefactor_o,
   output logic [1:0]       acr_sel_o,
   output logic             acr_we_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             ovf_o
);

   macctrl_state_e   state_q, state_d;
   logic [LEN_W-1:0] idx_q, idx_d;
   logic [1:0]       drain_q, drain_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             sub_q, sub_d, keep_q, keep_d, rnd_q, rnd_d, sat_q, sat_d;
   logic [2:0]       scale_q, scale_d;
   logic [1:0]       acr_q, acr_d;
   logic             ovf_q, ovf_d;
   logic             vld_p0_q, vld_p0_d, first_p0_q, first_p0_d;
   logic             vld_p1_q, vld_p1_d, first_p1_q, first_p1_d;
   logic             vld_p2_q, vld_p2_d, first_p2_q, first_p2_d;
   logic             issue, agu_load;
   logic [LEN_W-1:0] idx_inc;

   assign issue   = (state_q == ST_ISSUE);
   assign idx_inc = idx_q + LEN_W'(1);

   mac_loop_agu #(.AW(AW)) u_agu (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .load_i    (agu_load),
      .inc_i     (issue),
      .base_a_i  (base_a_i),
      .base_b_i  (base_b_i),
`ifdef MACCTRL_CIRC_A_EN
      .circ_len_i(circ_len_i),
`endif
      .addr_a_o  (addr_a_o),
      .addr_b_o  (addr_b_o)
   );

   // Output decode from registered state and tags.
   assign busy_o   = (state_q == ST_ISSUE) || (state_q == ST_DRAIN) ||
                     (state_q == ST_CLR)   || (state_q == ST_ROUND);
   assign done_o   = (state_q == ST_DONE);
   assign mem_re_o = issue;
   assign op_ld_o  = vld_p0_q;
   assign acr_we_o = vld_p2_q || (state_q == ST_CLR) || (state_q == ST_ROUND);
   assign acr_sel_o = acr_q;
   assign ovf_o    = ovf_q;
   assign c_dosat_o = busy_o && sat_q;
   // Rounding must see the raw accumulator, so the scale is dropped there.
   assign c_scalefactor_o = (busy_o && (state_q != ST_ROUND)) ? scale_q : 3'd0;

   always_comb begin
      c_macop_o = MAC_NOP;
      if (vld_p2_q)                c_macop_o = elem_macop(first_p2_q, keep_q, sub_q);
      else if (state_q == ST_CLR)  c_macop_o = MAC_CLR;
      else if (state_q == ST_ROUND) c_macop_o = MAC_MOVE_ROUND;
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      drain_d  = drain_q;
      len_d    = len_q;
      sub_d    = sub_q;
      keep_d   = keep_q;
      rnd_d    = rnd_q;
      sat_d    = sat_q;
      scale_d  = scale_q;
      acr_d    = acr_q;
      agu_load = 1'b0;
      // Flags are meaningful only in a cycle that writes the ACR.
      ovf_d    = ovf_q | (acr_we_o & (|ovf_flags_i));

      // Issue cycle t -> p0 (t+1, operand load) -> p1 (t+2, multiply)
      vld_p0_d   = issue;
      first_p0_d = issue && (idx_q == '0);
      // p1 -> p2 (t+3, accumulate opcode and ACR write)
      vld_p1_d   = vld_p0_q;
      first_p1_d = first_p0_q;
      vld_p2_d   = vld_p1_q;
      first_p2_d = first_p1_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               len_d    = len_i;
               sub_d    = sub_i;
               keep_d   = keep_acc_i;
               rnd_d    = rnd_i;
               sat_d    = sat_i;
               scale_d  = scale_i;
               acr_d    = acr_i;
               ovf_d    = 1'b0;
               idx_d    = '0;
               agu_load = 1'b1;
               if (len_i != '0)    state_d = ST_ISSUE;
               else if (!keep_acc_i) state_d = ST_CLR;
               else if (rnd_i)     state_d = ST_ROUND;
               else                state_d = ST_DONE;
            end
         end
         ST_ISSUE: begin
            idx_d = idx_inc;
            if (idx_inc == len_q) begin
               state_d = ST_DRAIN;
               drain_d = 2'd0;
            end
         end
         ST_DRAIN: begin
            drain_d = drain_q + 2'd1;
            if (drain_q == 2'(DRAIN_CYCLES - 1)) state_d = rnd_q ? ST_ROUND : ST_DONE;
         end
         ST_CLR:   state_d = rnd_q ? ST_ROUND : ST_DONE;
         ST_ROUND: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // Abort drops everything in flight; the sticky overflow is kept.
      if (abort_i && (state_q != ST_IDLE)) begin
         state_d    = ST_IDLE;
         vld_p0_d   = 1'b0;
         first_p0_d = 1'b0;
         vld_p1_d   = 1'b0;
         first_p1_d = 1'b0;
         vld_p2_d   = 1'b0;
         first_p2_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         drain_q    <= '0;
         len_q      <= '0;
         sub_q      <= 1'b0;
         keep_q     <= 1'b0;
         rnd_q      <= 1'b0;
         sat_q      <= 1'b0;
         scale_q    <= '0;
         acr_q      <= '0;
         ovf_q      <= 1'b0;
         vld_p0_q   <= 1'b0;
         first_p0_q <= 1'b0;
         vld_p1_q   <= 1'b0;
         first_p1_q <= 1'b0;
         vld_p2_q   <= 1'b0;
         first_p2_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         drain_q    <= drain_d;
         len_q      <= len_d;
         sub_q      <= sub_d;
         keep_q     <= keep_d;
         rnd_q      <= rnd_d;
         sat_q      <= sat_d;
         scale_q    <= scale_d;
         acr_q      <= acr_d;
         ovf_q      <= ovf_d;
         vld_p0_q   <= vld_p0_d;
         first_p0_q <= first_p0_d;
         vld_p1_q   <= vld_p1_d;
         first_p1_q <= first_p1_d;
         vld_p2_q   <= vld_p2_d;
         first_p2_q <= first_p2_d;
      end
   end

endmodule
